// File: rtl/dac_snapshot_capture.sv
// Triggered snapshot buffer on the DAC sample path.
// Taps the multi-lane DAC word at full rate, stores a fixed-length capture
// starting at a trigger rising edge, and replays it over a valid/ready stream.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for arm; len is latched on arm
// S_ARMED   | waiting for a trigger rising edge; arm re-latches len
// S_CAPTURE | writing valid input words until len words are stored
// S_READOUT | streaming words 0..len-1; arm aborts, last handshake -> idle
module dac_snapshot_capture #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int DEPTH_LOG2     = 10
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          arm,
  input  logic                          trigger,
  input  logic [DEPTH_LOG2:0]           capture_length,
  input  logic [16*NUMBER_OF_LINE-1:0]  data_in,
  input  logic                          data_in_valid,
  output logic [16*NUMBER_OF_LINE-1:0]  m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic [1:0]                    state,
  output logic                          done
);

  localparam int W     = 16 * NUMBER_OF_LINE;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t state_q;

  logic [W-1:0] mem [0:DEPTH-1];

  logic [DEPTH_LOG2:0]   len;
  logic [DEPTH_LOG2:0]   arm_len;
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic                  trigger_d;
  logic                  trig_edge;

  // write pipeline: input word registered once before the RAM write
  logic [W-1:0]          data_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic                  wr_q;
  logic                  wr_issue;

  // read pipeline: RAM output register, then output register plus skid
  logic [W-1:0]          rd_q;
  logic                  rd_pend;
  logic                  rd_last;
  logic                  rd_en;
  logic [W-1:0]          skid_data;
  logic                  skid_valid;
  logic                  skid_last;
  logic                  pop;
  logic [1:0]            occ;

  assign state     = state_q;
  assign trig_edge = trigger & ~trigger_d;
  assign pop       = m_valid & m_ready;
  assign occ       = 2'(m_valid) + 2'(skid_valid) + 2'(rd_pend);

  // Requested length with zero and oversize both meaning a full-depth capture
  always_comb begin
    arm_len = capture_length;
    if (capture_length == '0 || capture_length > FULL_LEN) arm_len = FULL_LEN;
  end

  // Decide whether the current input word is taken into the snapshot
  always_comb begin
    wr_issue = 1'b0;
    case (state_q)
      S_ARMED:   wr_issue = trig_edge & ~arm & data_in_valid;
      S_CAPTURE: wr_issue = data_in_valid & (wr_ptr < len);
      default:   wr_issue = 1'b0;
    endcase
  end

  // A read is issued only when the output register and skid can absorb it,
  // counting the word still in flight out of the RAM.
  assign rd_en = (state_q == S_READOUT) && !arm && (rd_ptr < len) &&
                 ((occ - 2'(pop)) < 2'd2);

  // Snapshot RAM: one write port, one registered read port, never reset
  always_ff @(posedge clock) begin
    if (wr_q) mem[addr_q] <= data_q;
    rd_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
  end

  // Control FSM, pointers, and the registered stream outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len        <= FULL_LEN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      trigger_d  <= 1'b1;
      data_q     <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      rd_pend    <= 1'b0;
      rd_last    <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      done       <= 1'b0;
    end else begin
      trigger_d <= trigger;
      done      <= 1'b0;

      data_q <= data_in;
      addr_q <= wr_ptr[DEPTH_LOG2-1:0];
      wr_q   <= wr_issue;
      if (wr_issue) wr_ptr <= wr_ptr + 1'b1;

      rd_pend <= rd_en;
      rd_last <= (rd_ptr == len - 1'b1);
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;

      case (state_q)
        S_IDLE: begin
          // an edge coinciding with arm is deliberately not consumed
          if (arm) begin
            len     <= arm_len;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            state_q <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (arm) begin
            len    <= arm_len;
            wr_ptr <= '0;
            rd_ptr <= '0;
          end else if (trig_edge) begin
            state_q <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          // all words issued; the final one lands in RAM on this same edge
          if (wr_ptr == len) state_q <= S_READOUT;
        end

        S_READOUT: begin
          if (arm) begin
            len        <= arm_len;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_pend    <= 1'b0;
            skid_valid <= 1'b0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            state_q    <= S_ARMED;
          end else begin
            if (pop) begin
              if (skid_valid) begin
                m_data     <= skid_data;
                m_last     <= skid_last;
                skid_valid <= rd_pend;
                skid_data  <= rd_q;
                skid_last  <= rd_last;
              end else if (rd_pend) begin
                m_data <= rd_q;
                m_last <= rd_last;
              end else begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
              end
            end else if (!m_valid) begin
              if (rd_pend) begin
                m_valid <= 1'b1;
                m_data  <= rd_q;
                m_last  <= rd_last;
              end
            end else if (rd_pend) begin
              skid_valid <= 1'b1;
              skid_data  <= rd_q;
              skid_last  <= rd_last;
            end

            if (pop && m_last) begin
              m_valid    <= 1'b0;
              m_last     <= 1'b0;
              skid_valid <= 1'b0;
              done       <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_snapshot_capture.sv
// Self-checking bench for dac_snapshot_capture: a stimulus-level model keeps
// the first len valid words from the trigger edge and compares the readout.
`timescale 1ns/1ps
module tb_dac_snapshot_capture;

  localparam int NL   = 8;
  localparam int DL   = 10;
  localparam int W    = 16 * NL;
  localparam int FULL = 1 << DL;

  logic          clock = 1'b0;
  logic          reset;
  logic          arm;
  logic          trigger;
  logic [DL:0]   capture_length;
  logic [W-1:0]  data_in;
  logic          data_in_valid;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [1:0]    state;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int last_pos, last_cnt, done_cnt, unstable;
  int first_rd, first_v, first_hs, last_hs;

  dac_snapshot_capture #(.NUMBER_OF_LINE(NL), .DEPTH_LOG2(DL)) dut (
    .clock          (clock),
    .reset          (reset),
    .arm            (arm),
    .trigger        (trigger),
    .capture_length (capture_length),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .state          (state),
    .done           (done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] lane_word(input int c);
    logic [W-1:0] w;
    for (int i = 0; i < NL; i++) w[16*i +: 16] = 16'(c * NL + i);
    return w;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W/32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic int model_len(input int req);
    return (req == 0 || req > FULL) ? FULL : req;
  endfunction

  function automatic int word_diffs();
    int n;
    n = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  // Arms (optionally), raises trigger, keeps feeding words and collects the
  // readout until the block has returned to idle for a few cycles.
  // gap_mode: 0 always valid, 1 every third word invalid, 2 random gaps.
  // base >= 0 drives lane_word(base+k) from the edge cycle, else random data.
  task automatic run_capture(input int len_req, input int gap_mode,
                             input int ready_mode, input bit do_arm,
                             input int base);
    int L, k, tail;
    bit v, prev_stall;
    logic [W-1:0] w, prev_data;
    logic prev_last;
    L = model_len(len_req);
    exp_q.delete();
    got_q.delete();
    last_pos = -1; last_cnt = 0; done_cnt = 0; unstable = 0;
    first_rd = -1; first_v = -1; first_hs = -1; last_hs = -1;
    trigger = 1'b0; m_ready = 1'b1; data_in_valid = 1'b1;
    data_in = (base >= 0) ? lane_word(base - 2) : rand_word();
    arm = do_arm;
    capture_length = (DL+1)'(len_req);
    step();
    arm = 1'b0;
    data_in = (base >= 0) ? lane_word(base - 1) : rand_word();
    step();
    k = 0; tail = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int it = 0; it < 5000 && tail < 4; it++) begin
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
        unstable++;
      if (done === 1'b1) done_cnt++;
      if (state === 2'd3 && first_rd < 0) first_rd = it;
      if (m_valid === 1'b1 && first_v < 0) first_v = it;
      trigger = 1'b1;
      case (gap_mode)
        1:       v = (k % 3) != 2;
        2:       v = $urandom_range(0, 3) != 0;
        default: v = 1'b1;
      endcase
      w = (base >= 0) ? lane_word(base + k) : rand_word();
      data_in = w;
      data_in_valid = v;
      if (v && exp_q.size() < L) exp_q.push_back(w);
      k++;
      m_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid === 1'b1 && m_ready) begin
        got_q.push_back(m_data);
        if (first_hs < 0) first_hs = it;
        last_hs = it;
        if (m_last === 1'b1) begin
          last_cnt++;
          last_pos = got_q.size() - 1;
        end
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (got_q.size() >= L && state === 2'd0) tail++;
      step();
    end
    trigger = 1'b0;
    data_in_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    run_capture(16, 0, 0, 1'b1, 100);
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL basic_count: got %0d expected 16", got_q.size()); end
    for (int j = 0; j < got_q.size() && j < 16; j++) begin
      checks++;
      if (got_q[j][15:0] !== 16'(800 + 8*j)) begin
        errors++; $display("FAIL basic_lane0[%0d]: got %0d expected %0d", j, got_q[j][15:0], 800 + 8*j);
      end
    end
    checks++; if (word_diffs() !== 0) begin errors++; $display("FAIL basic_words: %0d words differ, expected 0", word_diffs()); end
    checks++; if (last_pos !== 15 || last_cnt !== 1) begin errors++; $display("FAIL basic_last: pos %0d count %0d expected pos 15 count 1", last_pos, last_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL basic_state: got %0d expected 0", state); end
    checks++; if (last_hs - first_hs !== 15) begin errors++; $display("FAIL basic_full_rate: span %0d cycles expected 15", last_hs - first_hs); end
    checks++;
    if (first_rd < 0 || first_v < first_rd || first_v - first_rd > 3) begin
      errors++; $display("FAIL basic_first_valid: readout at %0d valid at %0d expected within 3", first_rd, first_v);
    end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 2; r++) begin
      run_capture(16 + r * 13, 0, 1, 1'b1, -1);
      checks++; if (got_q.size() !== 16 + r*13) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), 16 + r*13); end
      checks++; if (word_diffs() !== 0) begin errors++; $display("FAIL bp_words: %0d words differ, expected 0", word_diffs()); end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable stalls expected 0", unstable); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done: got %0d pulses expected 1", done_cnt); end
    end
  endtask

  task automatic test_gapped();
    run_capture(10, 1, 0, 1'b1, 300);
    checks++; if (got_q.size() !== 10) begin errors++; $display("FAIL gap_count: got %0d expected 10", got_q.size()); end
    checks++; if (word_diffs() !== 0) begin errors++; $display("FAIL gap_words: %0d words differ, expected 0", word_diffs()); end
    if (got_q.size() >= 3) begin
      checks++;
      if (got_q[2][15:0] !== 16'((300 + 3) * 8)) begin
        errors++; $display("FAIL gap_skip: word2 lane0 %0d expected %0d", got_q[2][15:0], (300 + 3) * 8);
      end
    end
    run_capture(37, 2, 1, 1'b1, -1);
    checks++; if (got_q.size() !== 37) begin errors++; $display("FAIL gap_rand_count: got %0d expected 37", got_q.size()); end
    checks++; if (word_diffs() !== 0) begin errors++; $display("FAIL gap_rand_words: %0d words differ, expected 0", word_diffs()); end
  endtask

  task automatic test_len_boundaries();
    int reqs[3];
    reqs[0] = 0; reqs[1] = 2000; reqs[2] = 1;
    for (int r = 0; r < 3; r++) begin
      run_capture(reqs[r], 0, 0, 1'b1, -1);
      checks++; if (got_q.size() !== model_len(reqs[r])) begin errors++; $display("FAIL len%0d_count: got %0d expected %0d", reqs[r], got_q.size(), model_len(reqs[r])); end
      checks++; if (word_diffs() !== 0) begin errors++; $display("FAIL len%0d_words: %0d words differ, expected 0", reqs[r], word_diffs()); end
      checks++; if (last_pos !== model_len(reqs[r]) - 1 || last_cnt !== 1) begin errors++; $display("FAIL len%0d_last: pos %0d count %0d expected pos %0d count 1", reqs[r], last_pos, last_cnt, model_len(reqs[r]) - 1); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL len%0d_done: got %0d pulses expected 1", reqs[r], done_cnt); end
    end
  endtask

  task automatic test_trigger_held_reset();
    trigger = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    arm = 1'b1;
    capture_length = (DL+1)'(6);
    step();
    arm = 1'b0;
    repeat (8) step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL held_trigger_state: got %0d expected 1", state); end
    run_capture(6, 0, 0, 1'b1, -1);
    checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL held_trigger_count: got %0d expected 6", got_q.size()); end
    checks++; if (word_diffs() !== 0) begin errors++; $display("FAIL held_trigger_words: %0d words differ, expected 0", word_diffs()); end
  endtask

  task automatic test_arm_edge_same();
    trigger = 1'b0;
    step();
    arm = 1'b1;
    trigger = 1'b1;
    capture_length = (DL+1)'(7);
    step();
    arm = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL arm_edge_state: got %0d expected 1", state); end
    repeat (6) step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL arm_edge_hold: got %0d expected 1", state); end
    run_capture(7, 0, 0, 1'b0, -1);
    checks++; if (got_q.size() !== 7) begin errors++; $display("FAIL arm_edge_count: got %0d expected 7", got_q.size()); end
    checks++; if (word_diffs() !== 0) begin errors++; $display("FAIL arm_edge_words: %0d words differ, expected 0", word_diffs()); end
  endtask

  task automatic test_rearm();
    trigger = 1'b0;
    arm = 1'b1;
    capture_length = (DL+1)'(20);
    step();
    arm = 1'b0;
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rearm_state: got %0d expected 1", state); end
    run_capture(5, 0, 1, 1'b1, -1);
    checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL rearm_count: got %0d expected 5", got_q.size()); end
    checks++; if (word_diffs() !== 0) begin errors++; $display("FAIL rearm_words: %0d words differ, expected 0", word_diffs()); end
  endtask

  task automatic test_abort();
    int hs, dc;
    trigger = 1'b0;
    m_ready = 1'b1;
    data_in_valid = 1'b1;
    arm = 1'b1;
    capture_length = (DL+1)'(30);
    step();
    arm = 1'b0;
    step();
    trigger = 1'b1;
    for (int it = 0; it < 200 && state !== 2'd3; it++) begin
      data_in = rand_word();
      step();
    end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL abort_reach_readout: got %0d expected 3", state); end
    hs = 0;
    for (int it = 0; it < 20 && hs < 3; it++) begin
      if (m_valid === 1'b1) hs++;
      step();
    end
    capture_length = (DL+1)'(8);
    arm = 1'b1;
    step();
    arm = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL abort_m_valid: got %b expected 0", m_valid); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL abort_state: got %0d expected 1", state); end
    dc = 0;
    for (int it = 0; it < 6; it++) begin
      if (done === 1'b1) dc++;
      step();
    end
    checks++; if (dc !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dc); end
    run_capture(8, 0, 1, 1'b0, -1);
    checks++; if (got_q.size() !== 8) begin errors++; $display("FAIL abort_len_count: got %0d expected 8", got_q.size()); end
    checks++; if (word_diffs() !== 0) begin errors++; $display("FAIL abort_len_words: %0d words differ, expected 0", word_diffs()); end
  endtask

  task automatic test_reset_mid_capture();
    trigger = 1'b0;
    data_in_valid = 1'b1;
    arm = 1'b1;
    capture_length = (DL+1)'(50);
    step();
    arm = 1'b0;
    step();
    trigger = 1'b1;
    for (int it = 0; it < 10; it++) begin
      data_in = rand_word();
      step();
    end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL midcap_state: got %0d expected 2", state); end
    reset = 1'b1;
    step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL midcap_reset_state: got %0d expected 0", state); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midcap_reset_valid: got %b expected 0", m_valid); end
    reset = 1'b0;
    step();
    run_capture(12, 2, 1, 1'b1, -1);
    checks++; if (got_q.size() !== 12) begin errors++; $display("FAIL midcap_after_count: got %0d expected 12", got_q.size()); end
    checks++; if (word_diffs() !== 0) begin errors++; $display("FAIL midcap_after_words: %0d words differ, expected 0", word_diffs()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL midcap_after_done: got %0d pulses expected 1", done_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    arm = 1'b0;
    trigger = 1'b0;
    capture_length = '0;
    data_in = '0;
    data_in_valid = 1'b0;
    m_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_len_boundaries();
    test_trigger_held_reset();
    test_arm_edge_same();
    test_rearm();
    test_abort();
    test_reset_mid_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
